// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one fixed-latency single-port memory between the
// fetch stage (read-only) and the memory stage (read/write) of the Y86-64 core.
// One access is in flight at a time; out-of-range addresses never reach the
// memory and come back flagged so the pipeline can raise ADR status.
module dmem_port_arbiter #(
  parameter int DEPTH        = 1024,
  parameter int AW           = 10,
  parameter int LATENCY      = 1,
  parameter int MAX_M_STREAK = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          f_req,
  input  logic [63:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [63:0]   f_rdata,
  output logic          f_err,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [63:0]   m_addr,
  input  logic [63:0]   m_wdata,
  output logic          m_gnt,
  output logic          m_rvalid,
  output logic [63:0]   m_rdata,
  output logic          m_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata,
  output logic          busy
);

  localparam int SW = $clog2(MAX_M_STREAK + 1);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_M_STREAK);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SW-1:0]   streak;
  logic [CW-1:0]   wait_cnt;

  // Latched transaction (data only, no reset needed: consumed after a grant)
  logic            owner_m;
  logic            we_lat;
  logic            err_lat;
  logic [AW-1:0]   addr_lat;
  logic [63:0]     wdata_lat;
  logic [63:0]     rdata_cap;

  logic            grant_f;
  logic            grant_m;
  logic            grant_any;
  logic [63:0]     sel_addr;
  logic            sel_err;
  logic [63:0]     resp_data;

  // Any of the 64 address bits beyond the last legal word makes it illegal.
  function automatic logic out_of_range(input logic [63:0] a);
    return a > 64'(DEPTH - 1);
  endfunction

  // Arbitration: memory stage wins unless fetch has waited MAX_M_STREAK grants.
  always_comb begin
    grant_f = 1'b0;
    grant_m = 1'b0;
    if (reset_n && state == S_IDLE) begin
      if (m_req && !(f_req && streak == STREAK_MAX)) begin
        grant_m = 1'b1;
      end else if (f_req) begin
        grant_f = 1'b1;
      end
    end
  end

  assign grant_any = grant_f | grant_m;
  assign sel_addr  = grant_m ? m_addr : f_addr;
  assign sel_err   = out_of_range(sel_addr);

  // Next-state logic for the access sequencer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (grant_any) state_nxt = sel_err ? S_ERR : S_ACCESS;
      S_ACCESS: state_nxt = S_WAIT;
      S_WAIT:   if (wait_cnt == WAIT_LAST) state_nxt = S_RESP;
      S_ERR:    state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control registers: state, fairness streak and wait counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      streak   <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant_f) begin
        streak <= '0;
      end else if (grant_m) begin
        streak <= f_req ? streak + 1'b1 : '0;
      end
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Transaction capture at grant, read data capture on the last WAIT cycle.
  always_ff @(posedge clock) begin
    if (grant_any) begin
      owner_m   <= grant_m;
      we_lat    <= grant_m & m_we;
      addr_lat  <= sel_addr[AW-1:0];
      wdata_lat <= m_wdata;
      err_lat   <= sel_err;
    end
    if (state == S_WAIT && wait_cnt == WAIT_LAST) begin
      rdata_cap <= mem_rdata;
    end
  end

  // Output decode; everything is forced low while reset_n is asserted.
  always_comb begin
    f_gnt     = grant_f;
    m_gnt     = grant_m;
    busy      = reset_n && (state != S_IDLE);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    f_rvalid  = 1'b0;
    f_rdata   = '0;
    f_err     = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_err     = 1'b0;
    resp_data = (err_lat || we_lat) ? 64'd0 : rdata_cap;
    if (reset_n) begin
      if (state == S_ACCESS) begin
        mem_en    = 1'b1;
        mem_we    = we_lat;
        mem_addr  = addr_lat;
        mem_wdata = wdata_lat;
      end
      if (state == S_RESP) begin
        if (owner_m) begin
          m_rvalid = 1'b1;
          m_rdata  = resp_data;
          m_err    = err_lat;
        end else begin
          f_rvalid = 1'b1;
          f_rdata  = resp_data;
          f_err    = err_lat;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (LATENCY 1 and 3), request
// drivers fed from command queues, a spec-level reference model that predicts
// grants and pushes expected responses, and a separate response monitor.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
  localparam int DEPTH   = 1024;
  localparam int AW      = 10;
  localparam int MAXS    = 4;
  localparam int LAT0    = 1;
  localparam int LAT1    = 3;
  localparam int TIMEOUT = 300;

  typedef struct { bit m; bit we; logic [63:0] addr; logic [63:0] wdata; int hold; } cmd_t;
  typedef struct { bit m; logic [63:0] data; bit err; longint due; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset_n  [2];
  logic          f_req    [2];
  logic [63:0]   f_addr   [2];
  logic          f_gnt    [2];
  logic          f_rvalid [2];
  logic [63:0]   f_rdata  [2];
  logic          f_err    [2];
  logic          m_req    [2];
  logic          m_we     [2];
  logic [63:0]   m_addr   [2];
  logic [63:0]   m_wdata  [2];
  logic          m_gnt    [2];
  logic          m_rvalid [2];
  logic [63:0]   m_rdata  [2];
  logic          m_err    [2];
  logic          mem_en   [2];
  logic          mem_we   [2];
  logic [AW-1:0] mem_addr [2];
  logic [63:0]   mem_wdata[2];
  logic [63:0]   mem_rdata[2];
  logic          busy     [2];

  dmem_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .LATENCY(LAT0), .MAX_M_STREAK(MAXS)) u_dut0 (
    .clock(clk), .reset_n(reset_n[0]),
    .f_req(f_req[0]), .f_addr(f_addr[0]), .f_gnt(f_gnt[0]), .f_rvalid(f_rvalid[0]),
    .f_rdata(f_rdata[0]), .f_err(f_err[0]),
    .m_req(m_req[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_gnt(m_gnt[0]), .m_rvalid(m_rvalid[0]), .m_rdata(m_rdata[0]), .m_err(m_err[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]));

  dmem_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .LATENCY(LAT1), .MAX_M_STREAK(MAXS)) u_dut1 (
    .clock(clk), .reset_n(reset_n[1]),
    .f_req(f_req[1]), .f_addr(f_addr[1]), .f_gnt(f_gnt[1]), .f_rvalid(f_rvalid[1]),
    .f_rdata(f_rdata[1]), .f_err(f_err[1]),
    .m_req(m_req[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_gnt(m_gnt[1]), .m_rvalid(m_rvalid[1]), .m_rdata(m_rdata[1]), .m_err(m_err[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]));

  // ---------------- counters and helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int timeouts = 0;

  function automatic void chk(string name, int k, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[inst%0d] cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
    end
  endfunction

  function automatic int lat(int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [63:0] init_word(int k, longint a);
    return {32'hC0DE_0000 + 32'(k), 32'(a) ^ 32'h5A5A_0000};
  endfunction

  // ---------------- memory attached to each DUT ----------------
  logic [63:0] ram [longint];
  logic [63:0] pipe [2][3];

  always @(posedge clk) begin
    logic [63:0] rd;
    longint key;
    for (int k = 0; k < 2; k++) begin
      rd = {$urandom, $urandom};
      if (mem_en[k]) begin
        key = longint'(k) * 4096 + longint'(mem_addr[k]);
        rd = ram.exists(key) ? ram[key] : init_word(k, longint'(mem_addr[k]));
        if (mem_we[k]) ram[key] = mem_wdata[k];
      end
      pipe[k][2] <= pipe[k][1];
      pipe[k][1] <= pipe[k][0];
      pipe[k][0] <= rd;
    end
  end
  assign mem_rdata[0] = pipe[0][LAT0-1];
  assign mem_rdata[1] = pipe[1][LAT1-1];

  // ---------------- reference model ----------------
  logic [63:0] ref_mem [longint];
  int          busy_left [2];
  int          phase     [2];
  int          streak    [2];
  bit          cur_err   [2];
  bit          cur_we    [2];
  logic [63:0] cur_addr  [2];
  logic [63:0] cur_wdata [2];
  exp_t        sbq  [2][$];
  bit          gseq [2][$];

  // Predicts grants, busy and the memory strobe; pushes expected responses.
  always @(negedge clk) begin
    exp_t   e;
    bit     want_m, want_f;
    longint key;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n[k]) begin
        chk("rst_gnt", k, 64'({f_gnt[k], m_gnt[k]}), 64'd0);
        chk("rst_outs", k, 64'({busy[k], mem_en[k], f_rvalid[k], m_rvalid[k]}), 64'd0);
        busy_left[k] = 0;
        phase[k]     = 0;
        streak[k]    = 0;
        sbq[k].delete();
      end else if (busy_left[k] > 0) begin
        phase[k]++;
        chk("busy", k, 64'(busy[k]), 64'd1);
        chk("gnt_while_busy", k, 64'({f_gnt[k], m_gnt[k]}), 64'd0);
        chk("mem_en", k, 64'(mem_en[k]), 64'((phase[k] == 1) && !cur_err[k]));
        if (phase[k] == 1 && !cur_err[k]) begin
          chk("mem_we", k, 64'(mem_we[k]), 64'(cur_we[k]));
          chk("mem_addr", k, 64'(mem_addr[k]), 64'(cur_addr[k][AW-1:0]));
          if (cur_we[k]) chk("mem_wdata", k, mem_wdata[k], cur_wdata[k]);
        end
        busy_left[k]--;
      end else begin
        want_m = m_req[k] && !(f_req[k] && streak[k] == MAXS);
        want_f = f_req[k] && !want_m;
        chk("busy_idle", k, 64'(busy[k]), 64'd0);
        chk("mem_en_idle", k, 64'(mem_en[k]), 64'd0);
        chk("grant", k, 64'({f_gnt[k], m_gnt[k]}), 64'({want_f, want_m}));
        if (want_m || want_f) begin
          gseq[k].push_back(want_m);
          cur_addr[k]  = want_m ? m_addr[k] : f_addr[k];
          cur_we[k]    = want_m && m_we[k];
          cur_wdata[k] = m_wdata[k];
          cur_err[k]   = cur_addr[k] > 64'(DEPTH - 1);
          e.m    = want_m;
          e.err  = cur_err[k];
          e.data = 64'd0;
          if (!cur_err[k]) begin
            key = longint'(k) * 4096 + longint'(cur_addr[k]);
            if (cur_we[k]) ref_mem[key] = cur_wdata[k];
            else e.data = ref_mem.exists(key) ? ref_mem[key] : init_word(k, longint'(cur_addr[k]));
          end
          busy_left[k] = cur_err[k] ? 2 : lat(k) + 2;
          phase[k]     = 0;
          e.due        = cyc + longint'(busy_left[k]);
          sbq[k].push_back(e);
          if (want_f) streak[k] = 0;
          else if (f_req[k]) streak[k]++;
          else streak[k] = 0;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (reset_n[k]) begin
        if (f_rvalid[k] || m_rvalid[k]) begin
          if (sbq[k].size() == 0) begin
            chk("unexpected_rvalid", k, 64'({f_rvalid[k], m_rvalid[k]}), 64'd0);
          end else begin
            e = sbq[k].pop_front();
            chk("resp_owner", k, 64'({f_rvalid[k], m_rvalid[k]}), 64'({!e.m, e.m}));
            chk("resp_cycle", k, 64'(cyc), 64'(e.due));
            if (e.m) begin
              chk("m_rdata", k, m_rdata[k], e.data);
              chk("m_err", k, 64'(m_err[k]), 64'(e.err));
              chk("f_quiet", k, f_rdata[k] | 64'(f_err[k]), 64'd0);
            end else begin
              chk("f_rdata", k, f_rdata[k], e.data);
              chk("f_err", k, 64'(f_err[k]), 64'(e.err));
              chk("m_quiet", k, m_rdata[k] | 64'(m_err[k]), 64'd0);
            end
          end
        end else begin
          chk("idle_resp", k, f_rdata[k] | m_rdata[k] | 64'({f_err[k], m_err[k]}), 64'd0);
          if (sbq[k].size() > 0 && sbq[k][0].due <= cyc) begin
            e = sbq[k].pop_front();
            chk("missing_rvalid", k, 64'({f_rvalid[k], m_rvalid[k]}), 64'({!e.m, e.m}));
          end
        end
      end
    end
  end

  // ---------------- request drivers ----------------
  cmd_t fq [2][$];
  cmd_t mq [2][$];

  task automatic drive(input int k, input bit is_m);
    cmd_t c;
    int   n;
    bit   got;
    forever begin
      if ((is_m ? mq[k].size() : fq[k].size()) == 0) begin
        @(posedge clk); #1;
        continue;
      end
      c = is_m ? mq[k][0] : fq[k][0];
      if (is_m) begin
        m_req[k] = 1'b1; m_we[k] = c.we; m_addr[k] = c.addr; m_wdata[k] = c.wdata;
      end else begin
        f_req[k] = 1'b1; f_addr[k] = c.addr;
      end
      n = 0;
      got = 1'b0;
      while (!got && n < TIMEOUT && !(c.hold > 0 && n >= c.hold)) begin
        @(negedge clk);
        n++;
        got = is_m ? m_gnt[k] : f_gnt[k];
      end
      if (!got && c.hold == 0) timeouts++;
      if (is_m) void'(mq[k].pop_front());
      else void'(fq[k].pop_front());
      @(posedge clk); #1;
      if (is_m) begin
        m_req[k] = 1'b0; m_we[k] = 1'($urandom); m_addr[k] = {$urandom, $urandom};
        m_wdata[k] = {$urandom, $urandom};
      end else begin
        f_req[k] = 1'b0; f_addr[k] = {$urandom, $urandom};
      end
    end
  endtask

  task automatic push_m(input int k, input bit we, input logic [63:0] addr,
                        input logic [63:0] wdata);
    cmd_t c;
    c.m = 1'b1; c.we = we; c.addr = addr; c.wdata = wdata; c.hold = 0;
    mq[k].push_back(c);
  endtask

  task automatic push_f(input int k, input logic [63:0] addr);
    cmd_t c;
    c.m = 1'b0; c.we = 1'b0; c.addr = addr; c.wdata = 64'd0; c.hold = 0;
    fq[k].push_back(c);
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while ((fq[k].size() != 0 || mq[k].size() != 0 || busy_left[k] != 0 ||
            sbq[k].size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    if (n >= 3000) timeouts++;
  endtask

  function automatic logic [63:0] rand_addr();
    int r = $urandom_range(0, 15);
    if (r == 0) return 64'(DEPTH + $urandom_range(0, 5));
    if (r == 1) return {1'b1, 31'($urandom), 32'($urandom)};
    if (r == 2) return 64'(DEPTH - 1);
    if (r == 3) return 64'd0;
    return 64'($urandom_range(0, 31));
  endfunction

  task automatic random_phase(input int k, input int n);
    cmd_t c;
    int   w;
    for (int i = 0; i < n; i++) begin
      c.m     = 1'($urandom_range(0, 1));
      c.we    = c.m && ($urandom_range(0, 1) == 1);
      c.addr  = rand_addr();
      c.wdata = {$urandom, $urandom};
      c.hold  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (c.m) mq[k].push_back(c);
      else fq[k].push_back(c);
      w = 0;
      while (fq[k].size() + mq[k].size() > 3 && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end
    wait_idle(k);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] seqv;
    int          n;
    for (int k = 0; k < 2; k++) begin
      reset_n[k] = 1'b0; f_req[k] = 1'b0; f_addr[k] = '0; m_req[k] = 1'b0;
      m_we[k] = 1'b0; m_addr[k] = '0; m_wdata[k] = '0;
    end
    fork
      drive(0, 1'b0);
      drive(0, 1'b1);
      drive(1, 1'b0);
      drive(1, 1'b1);
    join_none

    // Requests held high through reset, then write 5 / read 5 once released.
    push_m(0, 1'b1, 64'd5, 64'hDEAD);
    push_f(0, 64'd5);
    repeat (3) @(posedge clk);
    #1;
    reset_n[0] = 1'b1;
    wait_idle(0);

    // Continuous contention: m,m,m,m,f,m,m,m,m,f.
    gseq[0].delete();
    for (int i = 0; i < 8; i++) push_m(0, 1'b0, 64'($urandom_range(0, 31)), 64'd0);
    for (int i = 0; i < 2; i++) push_f(0, 64'($urandom_range(0, 31)));
    wait_idle(0);
    seqv = '0;
    foreach (gseq[0][i]) seqv = {seqv[62:0], gseq[0][i]};
    chk("grant_order", 0, seqv, 64'b1111011110);

    // Address range boundaries.
    push_m(0, 1'b0, 64'd1024, 64'd0);
    wait_idle(0);
    push_m(0, 1'b0, 64'd1023, 64'd0);
    push_f(0, 64'h8000_0000_0000_0005);
    wait_idle(0);

    // Reset in the WAIT state of a memory-stage read drops the response.
    push_m(0, 1'b0, 64'd9, 64'd0);
    n = 0;
    while (!m_gnt[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeouts++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n[0] = 1'b0;
    @(posedge clk); #1;
    reset_n[0] = 1'b1;
    push_f(0, 64'd12);
    wait_idle(0);

    random_phase(0, 150);

    // LATENCY=3 instance: fetch read of 7, then mixed traffic.
    reset_n[1] = 1'b1;
    @(posedge clk); #1;
    push_f(1, 64'd7);
    wait_idle(1);
    push_m(1, 1'b1, 64'd7, 64'h0123_4567_89AB_CDEF);
    push_f(1, 64'd7);
    wait_idle(1);
    random_phase(1, 80);

    chk("driver_timeouts", 0, 64'(timeouts), 64'd0);
    chk("sb_left0", 0, 64'(sbq[0].size()), 64'd0);
    chk("sb_left1", 1, 64'(sbq[1].size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
